// File: rtl/mem_resp_demux.sv
// Routes memory read responses into one of three holding registers by a tag captured with the request.
// Optional response timeout compiled in with `define MEM_RESP_DEMUX_TIMEOUT_EN.
module mem_resp_demux #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_sel,
    input  logic             rsp_valid,
    input  logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [2:0]       upd,
    output logic             busy,
    output logic             err
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // a response is taken on a rising edge where rsp_valid is high while waiting.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] tag;
    logic       accept;
    logic       rsp_take;
    logic       timeout_hit;

    assign accept   = (state == IDLE) && req_valid;
    assign rsp_take = (state == WAIT) && rsp_valid;

`ifdef MEM_RESP_DEMUX_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    // A response arriving on the expiry cycle takes priority over the abort.
    assign timeout_hit = (state == WAIT) && !rsp_valid &&
                         (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if ((state == WAIT) && !rsp_valid && !timeout_hit) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    // No abort path: the parameter is only referenced to keep one interface for both builds.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = WAIT;
            WAIT: if (rsp_valid || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            WAIT: busy      = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag <= 2'b00;
        end else if (accept) begin
            tag <= req_sel;
        end
    end

    // Tag 2'b11 consumes the response without touching any holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_a <= '0;
            out_b <= '0;
            out_c <= '0;
            upd   <= 3'b000;
            err   <= 1'b0;
        end else begin
            upd <= 3'b000;
            err <= timeout_hit;
            if (rsp_take) begin
                case (tag)
                    2'b00: begin out_a <= rsp_data; upd <= 3'b001; end
                    2'b01: begin out_b <= rsp_data; upd <= 3'b010; end
                    2'b10: begin out_c <= rsp_data; upd <= 3'b100; end
                    default: upd <= 3'b000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_demux.sv
// Scoreboard bench for mem_resp_demux; the timeout scenarios follow MEM_RESP_DEMUX_TIMEOUT_EN.
module tb_mem_resp_demux;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_sel;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [W-1:0] out_c;
  logic [2:0]   upd;
  logic         busy;
  logic         err;

  logic [W+2:0] exp_q[$];
  logic [W-1:0] m_a, m_b, m_c;
  int           n_cmp;
  int           n_err;

  mem_resp_demux #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .upd(upd), .busy(busy), .err(err)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every upd pulse pops one expected {upd, data} entry
  always @(negedge clk) begin
    if (!rst && (upd != 3'b000)) begin
      logic [W-1:0] obs;
      obs = upd[0] ? out_a : (upd[1] ? out_b : out_c);
      if (exp_q.size() == 0) begin
        check("upd_unexpected", {upd, obs}, '0);
      end else begin
        check("sb_resp", {upd, obs}, exp_q.pop_front());
        check("sb_err_excl", err, 1'b0);
      end
    end
  end

  task automatic check_regs(input string tag);
    check({tag, "_a"}, out_a, m_a);
    check({tag, "_b"}, out_b, m_b);
    check({tag, "_c"}, out_c, m_c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_a = '0; m_b = '0; m_c = '0;
  endtask

  task automatic issue_req(input logic [1:0] sel);
    req_valid = 1'b1;
    req_sel   = sel;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic txn(input logic [1:0] sel, input logic [W-1:0] data, input int waits, input bit stray);
    logic [2:0] u;
    issue_req(sel);
    @(negedge clk);
    check("busy_accept", busy, 1'b1);
    check("ready_wait", req_ready, 1'b0);
    for (int i = 0; i < waits; i++) begin
      if (stray) begin
        req_valid = 1'b1;
        req_sel   = 2'b10;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("busy_wait", busy, 1'b1);
    end
    if (sel != 2'b11) begin
      u = 3'b001 << sel;
      exp_q.push_back({u, data});
      case (sel)
        2'b00: m_a = data;
        2'b01: m_b = data;
        default: m_c = data;
      endcase
    end
    rsp_valid = 1'b1;
    rsp_data  = data;
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rsp", req_ready, 1'b1);
    check("busy_after_rsp", busy, 1'b0);
    check_regs("regs_after_rsp");
    if (sel == 2'b11) check("upd_discard", upd, 3'b000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("upd_pulse_end", upd, 3'b000);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    req_sel = 2'b00;
    rsp_data = '0;
    do_reset();

    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_upd", upd, 3'b000);
    check("rst_err", err, 1'b0);
    check_regs("rst_regs");

    // instruction fetch into out_a, response one cycle after accept
    txn(2'b00, 32'h8C22_0004, 0, 1'b0);
    // data load into out_b after five wait cycles
    txn(2'b01, 32'hDEAD_BEEF, 5, 1'b0);
    // discard tag
    txn(2'b11, 32'h1234_5678, 1, 1'b0);

    // stray response while idle must be ignored
    rsp_valid = 1'b1;
    rsp_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    @(negedge clk);
    check("idle_rsp_upd", upd, 3'b000);
    check_regs("idle_rsp_regs");
    // new request during WAIT must not retag
    txn(2'b01, 32'h55AA_1234, 2, 1'b1);
    txn(2'b10, 32'h0BAD_CAFE, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      txn(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3), 1'b0);
    end

    // reset mid-WAIT with a simultaneous response
    issue_req(2'b00);
    rst       = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_valid = 1'b0;
    m_a = '0; m_b = '0; m_c = '0;
    @(negedge clk);
    check("rst_wait_upd", upd, 3'b000);
    check("rst_wait_ready", req_ready, 1'b1);
    check("rst_wait_busy", busy, 1'b0);
    check_regs("rst_wait_regs");

`ifdef MEM_RESP_DEMUX_TIMEOUT_EN
    begin
      int edges;
      bit seen;
      edges = 0;
      seen  = 1'b0;
      issue_req(2'b01);
      for (int i = 1; i <= 40 && !seen; i++) begin
        @(posedge clk);
        #1;
        @(negedge clk);
        if (err) begin
          seen  = 1'b1;
          edges = i;
        end
      end
      check("timeout_seen", seen, 1'b1);
      check("timeout_edges", edges, 16);
      check("timeout_ready", req_ready, 1'b1);
      check("timeout_upd", upd, 3'b000);
      check_regs("timeout_regs");
      @(posedge clk);
      #1;
      @(negedge clk);
      check("timeout_err_pulse", err, 1'b0);
    end
    // response on the expiry cycle wins over the abort
    txn(2'b10, 32'hA5A5_0F0F, 15, 1'b0);
    check("expiry_err", err, 1'b0);
`else
    // without the timeout the block waits indefinitely
    issue_req(2'b10);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("no_timeout_err", err, 1'b0);
    end
    check("no_timeout_busy", busy, 1'b1);
    m_c = 32'h7777_1111;
    exp_q.push_back({3'b100, m_c});
    rsp_valid = 1'b1;
    rsp_data  = m_c;
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    @(negedge clk);
    check_regs("late_rsp_regs");
`endif

    @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_resp_demux.md
MEM_RESP_DEMUX -- requirements
Module: mem_resp_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of response bus and holding registers.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, max WAIT cycles before abort (only with timeout compiled in).
REQ-003 SHALL have one clock and synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  requester issues memory read tagged with req_sel.
REQ-007 req_ready  output  1  block can accept a request (high only in IDLE).
REQ-008 req_sel  input  2  destination tag: 00->out_a, 01->out_b, 10->out_c, 11->discard.
REQ-009 rsp_valid  input  1  memory read data valid this cycle.
REQ-010 rsp_data  input  WIDTH  memory read data.
REQ-011 out_a, out_b, out_c  output  WIDTH each  holding registers (instruction, memory data, spare).
REQ-012 upd  output  3  one-cycle pulse; bit i high when holding register i updated.
REQ-013 busy  output  1  high while in WAIT.
REQ-014 err  output  1  one-cycle timeout pulse (tied 0 when timeout compiled out).

Function
REQ-015 SHALL implement FSM with states IDLE and WAIT.
REQ-016 IDLE: req_ready=1, busy=0; req_valid=1 captures req_sel into internal tag, clears wait counter, next state WAIT.
REQ-017 IDLE: rsp_valid ignored; no register, upd or err change.
REQ-018 WAIT: req_ready=0, busy=1; req_valid and req_sel ignored; tag held.
REQ-019 WAIT with rsp_valid=1 at edge N: register selected by tag loads rsp_data, visible after edge N; upd[tag] high for the following cycle only; next state IDLE.
REQ-020 Tag 11: response consumed, no holding register written, upd stays 000, next state IDLE.
REQ-021 Only one holding register SHALL change per response; others hold value.
REQ-022 Latency: request accepted at edge K, response earliest at edge K+1; new request accepted at the edge after response (back-to-back throughput one transaction per 2 cycles).
REQ-023 Holding registers SHALL retain value indefinitely between updates.
REQ-024 upd and err SHALL be registered outputs; never high simultaneously.

Reset
REQ-025 rst=1 at edge: state IDLE, out_a/out_b/out_c=0, upd=000, err=0, busy=0, tag=00, counter=0.
REQ-026 rst SHALL override every other input on the same edge, including mid-WAIT with rsp_valid=1 (response dropped, no upd).
REQ-027 After rst deasserts, req_ready=1 in the first cycle.

Configuration
REQ-028 Macro MEM_RESP_DEMUX_TIMEOUT_EN SHALL select the timeout feature.
REQ-029 Defined: counter increments each WAIT cycle without rsp_valid; on reaching TIMEOUT_CYCLES-1 without rsp_valid, next state IDLE, err pulses one cycle, no register written.
REQ-030 Defined: rsp_valid on the same cycle the counter expires SHALL win (normal update, no err).
REQ-031 Not defined: no counter logic; WAIT held until rsp_valid or rst; err tied 0.

Verification
REQ-032 Reset then req_sel=00 request, rsp_data=0x8C220004 one cycle later -> out_a=0x8C220004, upd=001 one cycle, out_b=out_c=0.
REQ-033 req_sel=01, rsp after 5 WAIT cycles with 0xDEADBEEF -> busy high 5+ cycles, out_b=0xDEADBEEF, upd=010, out_a unchanged.
REQ-034 req_sel=11, rsp 0x12345678 -> all outputs unchanged, upd=000, req_ready high next cycle.
REQ-035 rsp_valid=1 in IDLE with 0xFFFFFFFF; req_valid=1 in WAIT with req_sel=10 -> both ignored, tag and registers unchanged.
REQ-036 rst asserted during WAIT with simultaneous rsp_valid (0xCAFEF00D) -> all registers 0, upd=000, state IDLE.
REQ-037 With MEM_RESP_DEMUX_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> err pulse after 16 WAIT cycles, req_ready=1 next cycle; response exactly on expiry cycle -> upd set, err=0.
